// File: rtl/ifmaps_window_feeder.sv
// Turns a raster pixel stream into 5-row column slices for the MAC ifmaps FIFO.
// Optional synchronous soft clear: define IFMAPS_WINDOW_FEEDER_SOFT_CLR_EN to add the soft_clr port.
module ifmaps_window_feeder #(
  parameter int DATA_WIDTH = 1,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  localparam int COL_W = $clog2(IMG_WIDTH),
  localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  fifo_full,
`ifdef IFMAPS_WINDOW_FEEDER_SOFT_CLR_EN
  input  logic                  soft_clr,
`endif
  output logic [DATA_WIDTH-1:0] row0_out,
  output logic [DATA_WIDTH-1:0] row1_out,
  output logic [DATA_WIDTH-1:0] row2_out,
  output logic [DATA_WIDTH-1:0] row3_out,
  output logic [DATA_WIDTH-1:0] row4_out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [COL_W-1:0]      col_idx
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [4:0][DATA_WIDTH-1:0] slice_q, slice_d;

  logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb3_q [IMG_WIDTH];

  logic clr;
  logic adv;
  logic accept;
  logic col_last;
  logic row_last;

`ifdef IFMAPS_WINDOW_FEEDER_SOFT_CLR_EN
  assign clr = soft_clr;
`else
  assign clr = 1'b0;
`endif

  // The output register may be overwritten when empty or when the FIFO takes it this edge.
  assign adv       = ~valid_q | ~fifo_full;
  assign pix_ready = adv & ~clr;
  assign accept    = pix_valid & pix_ready;
  assign col_last  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last  = (row_q == ROW_W'(IMG_HEIGHT - 1));

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = valid_q;
    last_d    = last_q;
    col_idx_d = col_idx_q;
    slice_d   = slice_q;
    if (clr) begin
      col_d     = '0;
      row_d     = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      col_idx_d = '0;
    end else if (accept) begin
      slice_d[0] = lb3_q[col_q];
      slice_d[1] = lb2_q[col_q];
      slice_d[2] = lb1_q[col_q];
      slice_d[3] = lb0_q[col_q];
      slice_d[4] = pix_in;
      col_idx_d  = col_q;
      valid_d    = (row_q >= ROW_W'(4));
      last_d     = row_last & col_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (adv) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      col_idx_q <= '0;
      slice_q   <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      col_idx_q <= col_idx_d;
      slice_q   <= slice_d;
    end
  end

  // Line buffers carry no reset; stale rows are masked by the row>=4 gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb3_q[col_q] <= lb2_q[col_q];
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

  assign row0_out  = slice_q[0];
  assign row1_out  = slice_q[1];
  assign row2_out  = slice_q[2];
  assign row3_out  = slice_q[3];
  assign row4_out  = slice_q[4];
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign col_idx   = col_idx_q;

endmodule
